// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a single wait-state memory port
module mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_memrq,
  input  logic              m1_memrq,
  input  logic              m0_rnw,
  input  logic              m1_rnw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic              mem_memrq,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_grant, sel, rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  // On contention the master that did not win last time gets the port.
  assign sel = (m0_memrq && m1_memrq) ? ~last_grant : m1_memrq;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE   ? ((m0_memrq || m1_memrq) ? ACCESS : IDLE) :
               state == ACCESS ? (cnt == 4'd0 ? DONE : ACCESS) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= 4'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rnw_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else if (state == IDLE && (m0_memrq || m1_memrq)) begin
      grant      <= sel;
      last_grant <= sel;
      rnw_q      <= sel ? m1_rnw : m0_rnw;
      addr_q     <= sel ? m1_addr : m0_addr;
      wdata_q    <= sel ? m1_wdata : m0_wdata;
      cnt        <= 4'(WAIT_CYC - 1);
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else if (rnw_q && grant) m1_rdata <= mem_rdata;
      else if (rnw_q) m0_rdata <= mem_rdata;
    end
  always_comb begin
    mem_memrq = state == ACCESS;
    mem_rnw   = mem_memrq ? rnw_q : 1'b1;
    mem_addr  = mem_memrq ? addr_q : '0;
    mem_wdata = mem_memrq ? wdata_q : '0;
    m0_ready  = state == DONE && !grant;
    m1_ready  = state == DONE && grant;
    busy      = state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a WAIT_CYC=1 and a WAIT_CYC=3 arbiter sharing one stimulus
module tb_mem_arbiter;
  logic clk, rst_n;
  logic m0_memrq, m1_memrq, m0_rnw, m1_rnw;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata, mem_rdata;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [11:0] a_mem_addr, b_mem_addr;
  logic a_m0_ready, a_m1_ready, a_mem_memrq, a_mem_rnw, a_grant, a_busy;
  logic b_m0_ready, b_m1_ready, b_mem_memrq, b_mem_rnw, b_grant, b_busy;
  int compared = 0, mismatched = 0, r0 = 0, r1 = 0;
  logic exp_g [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .WAIT_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .m0_memrq(m0_memrq), .m1_memrq(m1_memrq),
    .m0_rnw(m0_rnw), .m1_rnw(m1_rnw), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata),
    .m0_ready(a_m0_ready), .m1_ready(a_m1_ready), .mem_memrq(a_mem_memrq), .mem_rnw(a_mem_rnw),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .grant(a_grant), .busy(a_busy));

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .WAIT_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .m0_memrq(m0_memrq), .m1_memrq(m1_memrq),
    .m0_rnw(m0_rnw), .m1_rnw(m1_rnw), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
    .m0_ready(b_m0_ready), .m1_ready(b_m1_ready), .mem_memrq(b_mem_memrq), .mem_rnw(b_mem_rnw),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .grant(b_grant), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; m0_memrq = 0; m1_memrq = 0; m0_rnw = 1; m1_rnw = 1;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; mem_rdata = '0;
    step(); step();
    chk("rst_memrq", a_mem_memrq, 0);
    chk("rst_rnw", a_mem_rnw, 1);
    chk("rst_addr", a_mem_addr, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", {a_m0_ready, a_m1_ready}, 0);
    chk("rst_rdata", {a_m0_rdata, a_m1_rdata}, 0);
    rst_n = 1;
    step();
    // m0 read, single wait cycle
    m0_memrq = 1; m0_rnw = 1; m0_addr = 12'h0A5; mem_rdata = 16'h1234;
    step();
    chk("rd_memrq", a_mem_memrq, 1);
    chk("rd_addr", a_mem_addr, 12'h0A5);
    chk("rd_rnw", a_mem_rnw, 1);
    chk("rd_busy", a_busy, 1);
    chk("rd_ready_early", a_m0_ready, 0);
    m0_memrq = 0;
    step();
    chk("rd_memrq_done", a_mem_memrq, 0);
    chk("rd_m0_ready", a_m0_ready, 1);
    chk("rd_m1_ready", a_m1_ready, 0);
    chk("rd_m0_rdata", a_m0_rdata, 16'h1234);
    step();
    chk("rd_ready_end", a_m0_ready, 0);
    chk("rd_busy_end", a_busy, 0);
    // m1 write
    m1_memrq = 1; m1_rnw = 0; m1_addr = 12'hFFF; m1_wdata = 16'hBEEF; mem_rdata = 16'h7777;
    step();
    chk("wr_rnw", a_mem_rnw, 0);
    chk("wr_addr", a_mem_addr, 12'hFFF);
    chk("wr_wdata", a_mem_wdata, 16'hBEEF);
    chk("wr_grant", a_grant, 1);
    m1_memrq = 0;
    step();
    chk("wr_m1_ready", a_m1_ready, 1);
    chk("wr_m0_ready", a_m0_ready, 0);
    chk("wr_m1_rdata", a_m1_rdata, 16'h0000);
    step();
    chk("wr_ready_end", a_m1_ready, 0);
    chk("wr_idle_rnw", a_mem_rnw, 1);
    chk("wr_idle_wdata", a_mem_wdata, 0);
    // continuous dual requests alternate
    m0_memrq = 1; m1_memrq = 1; m0_rnw = 1; m1_rnw = 1; mem_rdata = 16'hC0DE;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), a_grant, exp_g[i]);
      r0 += int'(a_m0_ready); r1 += int'(a_m1_ready);
      step();
      chk($sformatf("rr_ready%0d", i), {a_m0_ready, a_m1_ready}, exp_g[i] ? 2'b01 : 2'b10);
      r0 += int'(a_m0_ready); r1 += int'(a_m1_ready);
      step();
      r0 += int'(a_m0_ready); r1 += int'(a_m1_ready);
    end
    m0_memrq = 0; m1_memrq = 0;
    chk("rr_m0_count", r0, 3);
    chk("rr_m1_count", r1, 3);
    chk("rr_m1_rdata", a_m1_rdata, 16'hC0DE);
    step();
    chk("rr_idle", a_busy, 0);
    // WAIT_CYC=3 read: last ACCESS cycle's data is captured
    rst_n = 0; step(); rst_n = 1; step();
    m0_memrq = 1; m0_rnw = 1; m0_addr = 12'h010; mem_rdata = 16'h1111;
    step();
    chk("w3_memrq1", b_mem_memrq, 1);
    chk("w3_addr", b_mem_addr, 12'h010);
    m0_memrq = 0; mem_rdata = 16'h2222;
    step();
    chk("w3_memrq2", b_mem_memrq, 1);
    mem_rdata = 16'h3333;
    step();
    chk("w3_memrq3", b_mem_memrq, 1);
    chk("w3_ready_early", b_m0_ready, 0);
    mem_rdata = 16'h4444;
    step();
    chk("w3_memrq_done", b_mem_memrq, 0);
    chk("w3_ready", b_m0_ready, 1);
    chk("w3_rdata", b_m0_rdata, 16'h4444);
    step();
    chk("w3_ready_end", b_m0_ready, 0);
    // reset asserted mid-ACCESS
    m1_memrq = 1; m1_rnw = 1;
    step();
    chk("ab_grant_pre", b_grant, 1);
    chk("ab_memrq_pre", b_mem_memrq, 1);
    m1_memrq = 0;
    #2 rst_n = 0;
    #1;
    chk("ab_memrq_async", b_mem_memrq, 0);
    chk("ab_busy_async", b_busy, 0);
    step();
    rst_n = 1;
    r1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      r1 += int'(b_m1_ready);
    end
    chk("ab_no_ready", r1, 0);
    chk("ab_grant", b_grant, 0);
    chk("ab_busy", b_busy, 0);
    chk("ab_rdata", b_m0_rdata, 0);
    // drop request and change address mid-ACCESS
    m0_memrq = 1; m0_rnw = 0; m0_addr = 12'h123; m0_wdata = 16'h00AA;
    step();
    chk("dr_addr1", b_mem_addr, 12'h123);
    chk("dr_grant", b_grant, 0);
    m0_memrq = 0; m0_addr = 12'h3FF; m0_rnw = 1; m0_wdata = 16'h0000;
    step();
    chk("dr_addr2", b_mem_addr, 12'h123);
    chk("dr_rnw", b_mem_rnw, 0);
    chk("dr_wdata", b_mem_wdata, 16'h00AA);
    step();
    chk("dr_addr3", b_mem_addr, 12'h123);
    step();
    chk("dr_ready", b_m0_ready, 1);
    chk("dr_rdata", b_m0_rdata, 0);
    step();
    chk("dr_ready_end", b_m0_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
